// File: rtl/dec_pulse_gen.sv
// Sequential 3-to-8 one-hot decoder: each accepted code drives a timed one-hot strobe
// followed by an all-zero gap. Define DEC_PULSE_QUEUE_EN to add a one-entry code queue.
module dec_pulse_gen #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] a_in,
    input  logic       a_valid,
    output logic       a_ready,
    output logic [7:0] y_op,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] PULSE_CNT = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_CNT   = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] code_q, code_d;
    logic [7:0] onehot_q, onehot_d;
`ifdef DEC_PULSE_QUEUE_EN
    logic       queue_full_q, queue_full_d;
    logic [2:0] queue_code_q, queue_code_d;
`endif

    logic       accept;
    logic       launch;
    logic       end_of_phase;
    logic [2:0] launch_code;

    assign accept = a_valid && a_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            onehot_q <= '0;
`ifdef DEC_PULSE_QUEUE_EN
            queue_full_q <= 1'b0;
            queue_code_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            onehot_q <= onehot_d;
`ifdef DEC_PULSE_QUEUE_EN
            queue_full_q <= queue_full_d;
            queue_code_q <= queue_code_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        onehot_d     = onehot_q;
        launch       = 1'b0;
        end_of_phase = 1'b0;
        launch_code  = a_in;
`ifdef DEC_PULSE_QUEUE_EN
        queue_full_d = queue_full_q;
        queue_code_d = queue_code_q;
`endif
        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            onehot_d = '0;
`ifdef DEC_PULSE_QUEUE_EN
            queue_full_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: launch = accept;
                DRIVE: begin
                    if (cnt_q == 4'd0) begin
                        if (GAP_LEN > 0) begin
                            state_d  = GAP;
                            cnt_d    = GAP_CNT;
                            onehot_d = '0;
                        end else begin
                            end_of_phase = 1'b1;
                        end
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                        onehot_d = 8'b1 << code_q;
                    end
                end
                GAP: begin
                    if (cnt_q == 4'd0) begin
                        end_of_phase = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (end_of_phase) begin
                state_d  = IDLE;
                cnt_d    = '0;
                onehot_d = '0;
`ifdef DEC_PULSE_QUEUE_EN
                // A waiting code (or one arriving right now) chains straight into DRIVE.
                if (queue_full_q) begin
                    launch       = 1'b1;
                    launch_code  = queue_code_q;
                    queue_full_d = 1'b0;
                end else begin
                    launch = accept;
                end
`endif
            end
`ifdef DEC_PULSE_QUEUE_EN
            else if (accept && state_q != IDLE) begin
                queue_full_d = 1'b1;
                queue_code_d = a_in;
            end
`endif

            if (launch) begin
                state_d  = DRIVE;
                cnt_d    = PULSE_CNT;
                code_d   = launch_code;
                onehot_d = 8'b1 << launch_code;
            end
        end
    end

    always_comb begin
`ifdef DEC_PULSE_QUEUE_EN
        a_ready = en && !queue_full_q;
`else
        a_ready = en && (state_q == IDLE);
`endif
        busy = (state_q != IDLE);
        // An aborted pulse must not report completion.
        done = en && (state_q == DRIVE) && (cnt_q == 4'd0);
    end

    assign y_op = en ? onehot_q : 8'bz;

endmodule

// File: tb/tb_dec_pulse_gen.sv
// Directed bench for dec_pulse_gen: three instances (4/1, 1/0, 4/0 pulse/gap) share
// one stimulus bus; each task checks the instance its scenario targets.
module tb_dec_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       a_valid;
    logic [2:0] a_in;

    logic       ar_a, busy_a, done_a;
    logic [7:0] y_a;
    logic       ar_b, busy_b, done_b;
    logic [7:0] y_b;
    logic       ar_c, busy_c, done_c;
    logic [7:0] y_c;

    logic [7:0] z8;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dec_pulse_gen #(.PULSE_LEN(4), .GAP_LEN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .a_valid(a_valid),
        .a_ready(ar_a), .y_op(y_a), .busy(busy_a), .done(done_a)
    );
    dec_pulse_gen #(.PULSE_LEN(1), .GAP_LEN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .a_valid(a_valid),
        .a_ready(ar_b), .y_op(y_b), .busy(busy_b), .done(done_b)
    );
    dec_pulse_gen #(.PULSE_LEN(4), .GAP_LEN(0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .a_valid(a_valid),
        .a_ready(ar_c), .y_op(y_c), .busy(busy_c), .done(done_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n   = 1'b0;
        en      = 1'b1;
        a_valid = 1'b0;
        a_in    = 3'd0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        en      = 1'b1;
        a_valid = 1'b0;
        a_in    = 3'd0;
        #2;
        n_vec++; if (y_a !== 8'h00) begin n_err++; $display("FAIL reset_y got %h want 00", y_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_a); end
        n_vec++; if (ar_a !== 1'b1) begin n_err++; $display("FAIL reset_ready_en1 got %b want 1", ar_a); end
        en = 1'b0;
        #1;
        n_vec++; if (y_a !== z8) begin n_err++; $display("FAIL reset_y_en0 got %h want zz", y_a); end
        n_vec++; if (ar_a !== 1'b0) begin n_err++; $display("FAIL reset_ready_en0 got %b want 0", ar_a); end
        en = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        $display("reset: checked en=1 and en=0 reset outputs");
    endtask

    task automatic test_default_pulse;
        apply_reset();
        a_in    = 3'd5;
        a_valid = 1'b1;
        n_vec++; if (ar_a !== 1'b1) begin n_err++; $display("FAIL dflt_ready_idle got %b want 1", ar_a); end
        tick();
        a_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (y_a !== 8'h20) begin n_err++; $display("FAIL dflt_drive_y c%0d got %h want 20", i, y_a); end
            n_vec++; if (done_a !== (i == 4)) begin n_err++; $display("FAIL dflt_done c%0d got %b want %b", i, done_a, (i == 4)); end
            n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL dflt_busy c%0d got %b want 1", i, busy_a); end
            tick();
        end
        n_vec++; if (y_a !== 8'h00) begin n_err++; $display("FAIL dflt_gap_y got %h want 00", y_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL dflt_gap_busy got %b want 1", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL dflt_gap_done got %b want 0", done_a); end
        tick();
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL dflt_idle_busy got %b want 0", busy_a); end
        n_vec++; if (ar_a !== 1'b1) begin n_err++; $display("FAIL dflt_idle_ready got %b want 1", ar_a); end
        $display("default: code 5 -> 4 cycles of 20, 1 gap cycle");
    endtask

    task automatic test_sweep;
        logic [7:0] exp_y;
        logic       exp_rdy;
`ifdef DEC_PULSE_QUEUE_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            a_in    = 3'(c);
            a_valid = 1'b1;
            exp_y   = 8'h01 << c;
            tick();
            a_valid = 1'b0;
            n_vec++; if (y_b !== exp_y) begin n_err++; $display("FAIL sweep_y code%0d got %h want %h", c, y_b, exp_y); end
            n_vec++; if (done_b !== 1'b1) begin n_err++; $display("FAIL sweep_done code%0d got %b want 1", c, done_b); end
            n_vec++; if (ar_b !== exp_rdy) begin n_err++; $display("FAIL sweep_ready_drive code%0d got %b want %b", c, ar_b, exp_rdy); end
            tick();
            n_vec++; if (y_b !== 8'h00) begin n_err++; $display("FAIL sweep_zero code%0d got %h want 00", c, y_b); end
            n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL sweep_busy code%0d got %b want 0", c, busy_b); end
            n_vec++; if (ar_b !== 1'b1) begin n_err++; $display("FAIL sweep_ready_idle code%0d got %b want 1", c, ar_b); end
            $display("sweep: code %0d -> %h", c, exp_y);
        end
    endtask

    task automatic test_enable_drop;
        apply_reset();
        a_in    = 3'd2;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        n_vec++; if (y_a !== 8'h04) begin n_err++; $display("FAIL endrop_c1_y got %h want 04", y_a); end
        tick();
        en = 1'b0;
        #1;
        n_vec++; if (y_a !== z8) begin n_err++; $display("FAIL endrop_hiz got %h want zz", y_a); end
        n_vec++; if (ar_a !== 1'b0) begin n_err++; $display("FAIL endrop_ready got %b want 0", ar_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL endrop_done_off got %b want 0", done_a); end
        tick();
        en = 1'b1;
        #1;
        n_vec++; if (y_a !== 8'h00) begin n_err++; $display("FAIL endrop_reen_y got %h want 00", y_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL endrop_reen_busy got %b want 0", busy_a); end
        n_vec++; if (ar_a !== 1'b1) begin n_err++; $display("FAIL endrop_reen_ready got %b want 1", ar_a); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL endrop_no_done c%0d got %b want 0", i, done_a); end
            n_vec++; if (y_a !== 8'h00) begin n_err++; $display("FAIL endrop_idle_y c%0d got %h want 00", i, y_a); end
        end
        $display("enable_drop: code 2 aborted in 2nd drive cycle");
    endtask

    task automatic test_back_to_back;
        apply_reset();
        a_in    = 3'd1;
        a_valid = 1'b1;
        tick();
`ifdef DEC_PULSE_QUEUE_EN
        n_vec++; if (ar_c !== 1'b1) begin n_err++; $display("FAIL b2b_q_ready_c1 got %b want 1", ar_c); end
        a_in = 3'd6;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (y_c !== 8'h02) begin n_err++; $display("FAIL b2b_q_y1 c%0d got %h want 02", i, y_c); end
            n_vec++; if (done_c !== (i == 4)) begin n_err++; $display("FAIL b2b_q_done1 c%0d got %b want %b", i, done_c, (i == 4)); end
            tick();
            if (i == 1) a_in = 3'd3;
            if (i < 4) begin
                n_vec++; if (ar_c !== 1'b0) begin n_err++; $display("FAIL b2b_q_stall c%0d got %b want 0", i, ar_c); end
            end
        end
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (y_c !== 8'h40) begin n_err++; $display("FAIL b2b_q_y6 c%0d got %h want 40", i, y_c); end
            n_vec++; if (done_c !== (i == 4)) begin n_err++; $display("FAIL b2b_q_done6 c%0d got %b want %b", i, done_c, (i == 4)); end
            if (i == 1) begin
                n_vec++; if (ar_c !== 1'b1) begin n_err++; $display("FAIL b2b_q_ready_after_launch got %b want 1", ar_c); end
            end
            tick();
            a_valid = 1'b0;
        end
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (y_c !== 8'h08) begin n_err++; $display("FAIL b2b_q_y3 c%0d got %h want 08", i, y_c); end
            tick();
        end
        n_vec++; if (y_c !== 8'h00) begin n_err++; $display("FAIL b2b_q_end_y got %h want 00", y_c); end
        n_vec++; if (busy_c !== 1'b0) begin n_err++; $display("FAIL b2b_q_end_busy got %b want 0", busy_c); end
        $display("back_to_back: queued codes 1,6,3 contiguous");
`else
        a_in = 3'd6;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (y_c !== 8'h02) begin n_err++; $display("FAIL b2b_y1 c%0d got %h want 02", i, y_c); end
            n_vec++; if (ar_c !== 1'b0) begin n_err++; $display("FAIL b2b_stall c%0d got %b want 0", i, ar_c); end
            tick();
        end
        n_vec++; if (y_c !== 8'h00) begin n_err++; $display("FAIL b2b_sep_y got %h want 00", y_c); end
        n_vec++; if (ar_c !== 1'b1) begin n_err++; $display("FAIL b2b_sep_ready got %b want 1", ar_c); end
        tick();
        a_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (y_c !== 8'h40) begin n_err++; $display("FAIL b2b_y6 c%0d got %h want 40", i, y_c); end
            tick();
        end
        n_vec++; if (y_c !== 8'h00) begin n_err++; $display("FAIL b2b_end_y got %h want 00", y_c); end
        $display("back_to_back: codes 1,6 separated by 1 zero cycle");
`endif
    endtask

    task automatic test_reset_mid_pulse;
        apply_reset();
        a_in    = 3'd5;
        a_valid = 1'b1;
        tick();
        a_in = 3'd7;
        tick();
        a_valid = 1'b0;
        repeat (3) tick();
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL rstgap_in_gap_busy got %b want 1", busy_a); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (y_a !== 8'h00) begin n_err++; $display("FAIL rstgap_y got %h want 00", y_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rstgap_busy got %b want 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL rstgap_done got %b want 0", done_a); end
        n_vec++; if (ar_a !== 1'b1) begin n_err++; $display("FAIL rstgap_ready got %b want 1", ar_a); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++; if (busy_a !== 1'b0 || y_a !== 8'h00) begin
                n_err++; $display("FAIL rstgap_queue_lost c%0d got busy=%b y=%h want busy=0 y=00", i, busy_a, y_a);
            end
        end
        $display("reset_mid_gap: pending code dropped");

        a_in    = 3'd4;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        n_vec++; if (y_a !== 8'h10) begin n_err++; $display("FAIL rstdrv_pre_y got %h want 10", y_a); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (y_a !== 8'h00) begin n_err++; $display("FAIL rstdrv_y got %h want 00", y_a); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL rstdrv_no_done c%0d got %b want 0", i, done_a); end
        end
        $display("reset_mid_drive: code 4 cut off, no done");
    endtask

    initial begin
        z8 = 8'bz;
        test_reset();
        test_default_pulse();
        test_sweep();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
